// File: rtl/keypad_scanner_4x4_pkg.sv
// Shared types, key codes and keymap helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'b00,
    DEB_PRESS   = 2'b01,
    HELD        = 2'b10,
    DEB_RELEASE = 2'b11
  } state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical (row, col) position to key code.
  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = KEY_A;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = KEY_B;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = KEY_C;
      4'd12: code = KEY_STAR;
      4'd13: code = 4'h0;
      4'd14: code = KEY_HASH;
      4'd15: code = KEY_D;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // Index of the lowest-numbered active-low column; 0 if none is low.
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_4x4_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port lists.
interface keypad_scanner_4x4_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       key_strobe;
  logic [3:0] key_code;
  logic       digit_strobe;
  logic       op_strobe;
  logic       key_held;

  // Scanner side: reads columns, drives rows and key events.
  modport master (
    input  col_in,
    output row_out, key_strobe, key_code, digit_strobe, op_strobe, key_held
  );

  // Consumer/keypad side.
  modport slave (
    output col_in,
    input  row_out, key_strobe, key_code, digit_strobe, op_strobe, key_held
  );
endinterface

// File: rtl/keypad_scanner_4x4_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every CLK_DIV clocks.
module keypad_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST);

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: row scan, press/release debounce, one strobe per press.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_scanner_4x4_if.master  kp
);
  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_TICKS);

  logic       tick;
  logic [3:0] sync1_reg;
  logic [3:0] col_s_reg;
  state_t     state_reg, state_next;
  logic [1:0] row_idx_reg, row_idx_next;
  logic [1:0] col_idx_reg, col_idx_next;
  logic [7:0] deb_cnt_reg, deb_cnt_next;
  logic [3:0] key_code_reg, key_code_next;
  logic       key_held_reg, key_held_next;
  logic       key_strobe_reg, digit_strobe_reg, op_strobe_reg;
  logic       accept, release_done;
  logic [3:0] row_drive;

  keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Active-low one-hot row drive decoded from the current row index.
  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_drive[gi] = (row_idx_reg != 2'(gi));
  end

  assign kp.row_out      = row_drive;
  assign kp.key_strobe   = key_strobe_reg;
  assign kp.key_code     = key_code_reg;
  assign kp.digit_strobe = digit_strobe_reg;
  assign kp.op_strobe    = op_strobe_reg;
  assign kp.key_held     = key_held_reg;

  // Two-flop synchronizer for the asynchronous column inputs; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 4'b1111;
      col_s_reg <= 4'b1111;
    end else begin
      sync1_reg <= kp.col_in;
      col_s_reg <= sync1_reg;
    end
  end

  // Next-state logic; every decision is gated by the scan tick.
  always_comb begin
    state_next    = state_reg;
    row_idx_next  = row_idx_reg;
    col_idx_next  = col_idx_reg;
    deb_cnt_next  = deb_cnt_reg;
    key_code_next = key_code_reg;
    key_held_next = key_held_reg;
    accept        = 1'b0;
    release_done  = 1'b0;
    if (tick) begin
      case (state_reg)
        SCAN: begin
          if (col_s_reg != 4'b1111) begin
            col_idx_next = lowest_low_col(col_s_reg);
            deb_cnt_next = 8'd1;
            if (DEB_LIM == 8'd1) accept = 1'b1;
            else                 state_next = DEB_PRESS;
          end else begin
            row_idx_next = row_idx_reg + 2'd1;
          end
        end
        DEB_PRESS: begin
          if (!col_s_reg[col_idx_reg]) begin
            deb_cnt_next = deb_cnt_reg + 8'd1;
            if (deb_cnt_reg + 8'd1 == DEB_LIM) accept = 1'b1;
          end else begin
            // Bounce before acceptance: drop it and keep scanning.
            state_next   = SCAN;
            row_idx_next = row_idx_reg + 2'd1;
          end
        end
        HELD: begin
          // Row stays latched here so other keys cannot be seen.
          if (col_s_reg[col_idx_reg]) begin
            deb_cnt_next = 8'd1;
            if (DEB_LIM == 8'd1) release_done = 1'b1;
            else                 state_next = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (col_s_reg[col_idx_reg]) begin
            deb_cnt_next = deb_cnt_reg + 8'd1;
            if (deb_cnt_reg + 8'd1 == DEB_LIM) release_done = 1'b1;
          end else begin
            state_next = HELD;
          end
        end
        default: state_next = SCAN;
      endcase
    end
    if (accept) begin
      key_code_next = keymap(row_idx_reg, col_idx_next);
      key_held_next = 1'b1;
      state_next    = HELD;
    end
    if (release_done) begin
      key_held_next = 1'b0;
      state_next    = SCAN;
      row_idx_next  = row_idx_reg + 2'd1;
    end
  end

  // State and output registers; strobes last exactly one clock after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= SCAN;
      row_idx_reg      <= 2'd0;
      col_idx_reg      <= 2'd0;
      deb_cnt_reg      <= 8'd0;
      key_code_reg     <= 4'h0;
      key_held_reg     <= 1'b0;
      key_strobe_reg   <= 1'b0;
      digit_strobe_reg <= 1'b0;
      op_strobe_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      row_idx_reg      <= row_idx_next;
      col_idx_reg      <= col_idx_next;
      deb_cnt_reg      <= deb_cnt_next;
      key_code_reg     <= key_code_next;
      key_held_reg     <= key_held_next;
      key_strobe_reg   <= accept;
      digit_strobe_reg <= accept && is_digit(key_code_next);
      op_strobe_reg    <= accept && !is_digit(key_code_next);
    end
  end
endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4 with CLK_DIV=4, DEBOUNCE_TICKS=3 and a keypad matrix model.
module tb_keypad_scanner_4x4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_4x4_if kp_if();

  keypad_scanner_4x4 #(.CLK_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if)
  );

  // pressed[row*4+col]: key closed, shorting that column to its row
  logic [15:0] pressed = 16'h0;

  function automatic logic [3:0] col_model(input logic [3:0] rows, input logic [15:0] keys);
    logic [3:0] cols;
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
    return cols;
  endfunction

  assign kp_if.col_in = col_model(kp_if.row_out, pressed);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_count = 0;
  int last_strobe_cyc = 0;
  int base_cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  logic [5:0] mon_want;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each strobe pops the key expected when stimulus was applied.
  always @(negedge clk) begin
    if (kp_if.key_strobe === 1'b1) begin
      strobe_count++;
      last_strobe_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got code=%h want no strobe", kp_if.key_code);
      end else begin
        mon_e = exp_q.pop_front();
        mon_want = {(mon_e <= 4'd9), (mon_e > 4'd9), mon_e};
        if ({kp_if.digit_strobe, kp_if.op_strobe, kp_if.key_code} !== mon_want) begin
          failures++;
          $display("FAIL strobe_key got dig/op/code=%b/%b/%h want %b/%b/%h",
                   kp_if.digit_strobe, kp_if.op_strobe, kp_if.key_code,
                   mon_want[5], mon_want[4], mon_want[3:0]);
        end
      end
    end else if (kp_if.digit_strobe === 1'b1 || kp_if.op_strobe === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL stray_class_strobe got dig=%b op=%b want 0 without key_strobe",
               kp_if.digit_strobe, kp_if.op_strobe);
    end
  end

  task automatic wait_row(input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kp_if.row_out === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int prev, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      #1;
      if (strobe_count > prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kp_if.key_held === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kp_if.row_out, kp_if.key_strobe, kp_if.digit_strobe, kp_if.op_strobe,
         kp_if.key_held, kp_if.key_code} !== {4'b1110, 4'b0000, 4'h0}) begin
      failures++;
      $display("FAIL reset_values got row=%b stb=%b dig=%b op=%b held=%b code=%h want row=1110 all 0",
               kp_if.row_out, kp_if.key_strobe, kp_if.digit_strobe, kp_if.op_strobe,
               kp_if.key_held, kp_if.key_code);
    end
    reset = 1'b0;
    base_cyc = cyc;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_rows[5];
    logic [3:0] prev_row;
    int prev_cyc;
    bit seen;
    exp_rows = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    prev_row = kp_if.row_out;
    prev_cyc = base_cyc;
    for (int k = 0; k < 5; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (kp_if.row_out !== prev_row) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen || kp_if.row_out !== exp_rows[k] || (cyc - prev_cyc) != 4) begin
        failures++;
        $display("FAIL idle_scan step %0d got row=%b after %0d clks want row=%b after 4 clks",
                 k, kp_if.row_out, cyc - prev_cyc, exp_rows[k]);
      end
      prev_row = kp_if.row_out;
      prev_cyc = cyc;
    end
    checks++;
    if (strobe_count != 0) begin
      failures++;
      $display("FAIL idle_no_strobe got %0d strobes want 0", strobe_count);
    end
  endtask

  task automatic test_clean_press();
    bit ok;
    int r_cyc;
    int prev;
    wait_row(4'b0111, ok);
    wait_row(4'b1110, ok);
    pressed[8] = 1'b1;                 // '7' at r2,c0
    exp_q.push_back(4'h7);
    prev = strobe_count;
    wait_row(4'b1011, ok);
    r_cyc = cyc;
    wait_strobe(prev, 60, ok);
    checks++;
    if (!ok || (last_strobe_cyc - r_cyc) != 12) begin
      failures++;
      $display("FAIL press7_latency got strobe %0d clks after row2 drive (seen=%0d) want 12",
               last_strobe_cyc - r_cyc, ok);
    end
    repeat (80) @(posedge clk);
    @(negedge clk);
    checks++;
    if (strobe_count != prev + 1 || kp_if.key_code !== 4'h7 || kp_if.key_held !== 1'b1 ||
        kp_if.row_out !== 4'b1011) begin
      failures++;
      $display("FAIL press7_hold got strobes=%0d code=%h held=%b row=%b want %0d 7 1 1011",
               strobe_count - prev, kp_if.key_code, kp_if.key_held, kp_if.row_out, 1);
    end
    pressed[8] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.key_held !== 1'b1) begin
      failures++;
      $display("FAIL press7_held_early got held=%b want 1", kp_if.key_held);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.key_held !== 1'b0 || kp_if.key_code !== 4'h7) begin
      failures++;
      $display("FAIL press7_release got held=%b code=%h want held=0 code=7",
               kp_if.key_held, kp_if.key_code);
    end
  endtask

  task automatic test_press_bounce();
    bit ok;
    int prev;
    wait_row(4'b1011, ok);
    wait_row(4'b0111, ok);
    prev = strobe_count;
    pressed[14] = 1'b1;                // '#' at r3,c2
    repeat (4) @(posedge clk);
    @(negedge clk);
    pressed[14] = 1'b0;                // one-tick bounce inside press debounce
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.row_out !== 4'b1110 || strobe_count != prev || kp_if.key_held !== 1'b0) begin
      failures++;
      $display("FAIL hash_bounce got row=%b strobes=%0d held=%b want row=1110 strobes=0 held=0",
               kp_if.row_out, strobe_count - prev, kp_if.key_held);
    end
    pressed[14] = 1'b1;
    exp_q.push_back(4'hF);
    wait_strobe(prev, 120, ok);
    checks++;
    if (!ok || kp_if.key_code !== 4'hF || kp_if.key_held !== 1'b1) begin
      failures++;
      $display("FAIL hash_retry got seen=%0d code=%h held=%b want 1 F 1",
               ok, kp_if.key_code, kp_if.key_held);
    end
    pressed[14] = 1'b0;
    wait_held_low(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hash_release got held=%b want 0 within bound", kp_if.key_held);
    end
  endtask

  task automatic test_release_bounce();
    bit ok;
    int prev;
    prev = strobe_count;
    pressed[7] = 1'b1;                 // 'B' at r1,c3
    exp_q.push_back(4'hB);
    wait_strobe(prev, 120, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b_press got no strobe want one");
    end
    pressed[7] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pressed[7] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pressed[7] = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.key_held !== 1'b1) begin
      failures++;
      $display("FAIL b_release_bounce_held got held=%b want 1 (only 2 stable high ticks)",
               kp_if.key_held);
    end
    repeat (1) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.key_held !== 1'b0 || strobe_count != prev + 1) begin
      failures++;
      $display("FAIL b_release_done got held=%b strobes=%0d want held=0 strobes=1",
               kp_if.key_held, strobe_count - prev);
    end
  endtask

  task automatic test_two_keys();
    bit ok;
    int prev;
    prev = strobe_count;
    pressed[1] = 1'b1;                 // '2' at r0,c1
    pressed[2] = 1'b1;                 // '3' at r0,c2
    exp_q.push_back(4'h2);
    wait_strobe(prev, 120, ok);
    checks++;
    if (!ok || kp_if.key_code !== 4'h2) begin
      failures++;
      $display("FAIL same_row_pair got seen=%0d code=%h want 1 2", ok, kp_if.key_code);
    end
    pressed[5] = 1'b1;                 // '5' at r1,c1 while '2' still down
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (strobe_count != prev + 1 || kp_if.row_out !== 4'b1110 || kp_if.key_code !== 4'h2) begin
      failures++;
      $display("FAIL second_key_ignored got strobes=%0d row=%b code=%h want 1 1110 2",
               strobe_count - prev, kp_if.row_out, kp_if.key_code);
    end
    exp_q.push_back(4'h5);
    pressed[1] = 1'b0;
    pressed[2] = 1'b0;
    wait_strobe(prev + 1, 120, ok);
    checks++;
    if (!ok || kp_if.key_code !== 4'h5) begin
      failures++;
      $display("FAIL rescan_5 got seen=%0d code=%h want 1 5", ok, kp_if.key_code);
    end
    pressed[5] = 1'b0;
    wait_held_low(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL five_release got held=%b want 0 within bound", kp_if.key_held);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int prev;
    wait_row(4'b0111, ok);
    wait_row(4'b1110, ok);
    pressed[0] = 1'b1;                 // '1' at r0,c0
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;                      // mid press-debounce
    #1;
    checks++;
    if ({kp_if.row_out, kp_if.key_strobe, kp_if.key_held, kp_if.key_code} !== {4'b1110, 2'b00, 4'h0}) begin
      failures++;
      $display("FAIL reset_in_deb_press got row=%b stb=%b held=%b code=%h want 1110 0 0 0",
               kp_if.row_out, kp_if.key_strobe, kp_if.key_held, kp_if.key_code);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base_cyc = cyc;
    prev = strobe_count;
    exp_q.push_back(4'h1);
    wait_strobe(prev, 60, ok);
    checks++;
    if (!ok || (last_strobe_cyc - base_cyc) != 12) begin
      failures++;
      $display("FAIL post_reset_debounce got strobe %0d clks after reset release (seen=%0d) want 12",
               last_strobe_cyc - base_cyc, ok);
    end
    reset = 1'b1;                      // mid hold
    #1;
    checks++;
    if ({kp_if.key_held, kp_if.key_code, kp_if.row_out} !== {1'b0, 4'h0, 4'b1110}) begin
      failures++;
      $display("FAIL reset_in_held got held=%b code=%h row=%b want 0 0 1110",
               kp_if.key_held, kp_if.key_code, kp_if.row_out);
    end
    pressed[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev = strobe_count;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (strobe_count != prev || kp_if.key_held !== 1'b0) begin
      failures++;
      $display("FAIL post_held_reset got strobes=%0d held=%b want 0 0",
               strobe_count - prev, kp_if.key_held);
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_two_keys();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_strobes got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
Scans a 4x4 matrix keypad, debounces presses and releases, and emits exactly one registered strobe per physical press, with a 4-bit key code. It sits directly upstream of the number-entry and operator FSMs of the TP3 calculator. Its digit strobe and digit value feed the number-entry stage's digit-enable and new-digit inputs.

Parameters:
CLK_DIV, 1000, clk cycles per scan tick; must be >= 4 to cover the synchronizer delay.
DEBOUNCE_TICKS, 20, consecutive identical tick samples required to accept a press or a release; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
col_in  input  4  keypad columns; active-low with external pull-ups; asynchronous to clk
row_out  output  4  row drive; active-low one-hot; 4'b1111 never driven outside reset
key_strobe  output  1  one-cycle pulse per accepted press
key_code  output  4  code of the last accepted key; stable between strobes
digit_strobe  output  1  key_strobe AND key is 0-9
op_strobe  output  1  key_strobe AND key is A-F code
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset values:
  - row_out = 4'b1110 (row 0)
  - key_strobe, digit_strobe, op_strobe, key_held = 0
  - key_code = 4'h0
  - state = SCAN; tick counter = 0; debounce counter = 0; synchronizer flops = 4'b1111
  - Reset asserted mid-debounce or mid-hold aborts with no strobe.
- Input synchronization: col_in passes through a 2-flop synchronizer; all logic uses the synced value (col_s).
- Tick generation: free-running counter 0..CLK_DIV-1; tick is a one-cycle pulse when count == CLK_DIV-1. All FSM decisions happen only on tick cycles.
- Key map (row,col) -> code:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *=E, 0=0, #=F, D
  - Digits are codes 0x0-0x9. A-D are 0xA-0xD, *=0xE, #=0xF. op_strobe fires for all of 0xA-0xF.
- FSM states: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
- SCAN:
  - On tick, sample col_s for the currently driven row.
  - If any bit is low: latch row and the lowest-index low column, set deb_cnt = 1, go DEB_PRESS. The row stays driven.
  - Otherwise rotate row_out to the next row (r3 wraps to r0).
- DEB_PRESS:
  - On tick, if the latched column is low: deb_cnt++.
  - If the latched column is high: go SCAN, advance the row, no strobe.
  - When deb_cnt reaches DEBOUNCE_TICKS (checked immediately after entry when DEBOUNCE_TICKS = 1):
    - Register key_code.
    - Pulse key_strobe plus digit_strobe or op_strobe for exactly the next clk cycle.
    - Set key_held = 1 and go HELD.
  - Press-to-strobe latency: (DEBOUNCE_TICKS-1) ticks after the detection tick, plus 1 clk.
- HELD:
  - Row stays latched; no rescan, so ghost and second keys are ignored.
  - On a tick with the latched column high: deb_cnt = 1, go DEB_RELEASE.
- DEB_RELEASE:
  - On tick, if the latched column is high: deb_cnt++.
  - If the latched column is low again: go HELD (bounce; no new strobe).
  - When deb_cnt reaches DEBOUNCE_TICKS: key_held = 0, go SCAN and advance the row.
- Simultaneous keys:
  - Same row: the lowest column wins.
  - Different rows: the first row reached in the scan wins.
- Holding a key never repeats the strobe.
- key_code is never cleared by release.

Decomposition:
- Package keypad_pkg:
  - state encoding (SCAN=2'b00, DEB_PRESS=2'b01, HELD=2'b10, DEB_RELEASE=2'b11)
  - key code constants KEY_A..KEY_D, KEY_STAR=4'hE, KEY_HASH=4'hF
  - function keymap(row_idx, col_idx) -> code
  - function is_digit(code)
- Sub-module keypad_tick_gen (parameter CLK_DIV; outputs tick) is instantiated once.
- The synchronizer and FSM stay in the top block.

Test Plan:
Sim parameters CLK_DIV=4, DEBOUNCE_TICKS=3; the keypad model pulls col c low when the pressed key's row is driven.
1. Reset, no key -> row_out cycles 1110, 1101, 1011, 0111, 1110 on successive ticks; no strobes.
2. Clean press of '7' (r2,c0) held 20 ticks -> one key_strobe and one digit_strobe; key_code = 4'h7; strobe 2 ticks + 1 clk after the detection tick; key_held = 1 until 3 high ticks after release.
3. Press '#' with 1-tick bounce (low, high, low...) during DEB_PRESS -> back to SCAN with no strobe; stable retry -> one op_strobe, key_code = 4'hF.
4. Release bounce on 'B' (high 1 tick, low, then stable high) -> exactly one strobe total; key_held drops only after 3 consecutive high ticks.
5. '2' and '3' pressed together (r0,c1 and r0,c2) -> key_code = 4'h2; press '5' while '2' is still held -> no strobe until '2' is released and '5' is rescanned.
6. Reset asserted in DEB_PRESS and in HELD -> outputs return to reset values asynchronously; no strobe after deassertion until a full new debounce.
